console_uart_tx: RTL and testbench

Serial transmitter for the console path: buffers bytes from the CPU/IO-controller side in a small FIFO and sends them as 8N1 asynchronous serial, LSB first, on a single output line. It is the transmit-direction counterpart of the console receiver and shares its bit timing (default 115200 baud derived from the system clock frequency in MHz). It sits between the SoC's console register interface and the board's serial TX pin.

---
 rtl/console_uart_tx.sv | 104 ++++++++++
 tb/tb_console_uart_tx.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/console_uart_tx.sv
// console_uart_tx: FIFO-buffered 8N1 serial transmitter, LSB first, idle-high line.
module console_uart_tx #(
  parameter int CLKFREQ = 100,
  parameter int BAUD = 115200,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic n_reset,
  input  logic [7:0] par_in_data,
  input  logic par_in_strobe,
  output logic ser_out,
  output logic fifo_full,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic busy,
  output logic overflow
);
  localparam int TPB = (CLKFREQ * 1000000) / BAUD;
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TPB + 1);
  localparam logic [TW-1:0] RELOAD = TW'(TPB - 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic ser_q, ser_d, ovf_q, ovf_d, expire, pop, wr;
  always_comb begin
    expire = timer_q == '0;
    pop = count_q != '0 && (state_q == IDLE || (state_q == STOP && expire));
    wr = par_in_strobe && count_q != FULL;
    ovf_d = par_in_strobe && count_q == FULL;
    wptr_d = wptr_q + AW'(wr);
    rptr_d = rptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(wr) - (AW+1)'(pop);
    state_d = state_q;
    timer_d = expire ? '0 : timer_q - 1'b1;
    shift_d = shift_q;
    idx_d = idx_q;
    ser_d = ser_q;
    case (state_q)
      IDLE: if (pop) begin
        shift_d = mem[rptr_q];
        ser_d = 1'b0;
        timer_d = RELOAD;
        state_d = START;
      end
      START: if (expire) begin
        ser_d = shift_q[0];
        shift_d = shift_q >> 1;
        idx_d = '0;
        timer_d = RELOAD;
        state_d = DATA;
      end
      DATA: if (expire) begin
        timer_d = RELOAD;
        ser_d = idx_q == 3'd7 ? 1'b1 : shift_q[0];
        shift_d = shift_q >> 1;
        idx_d = idx_q + 3'd1;
        state_d = idx_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (expire) begin
        // a queued byte starts its frame on this edge, no idle gap
        shift_d = pop ? mem[rptr_q] : shift_q;
        ser_d = !pop;
        timer_d = pop ? RELOAD : '0;
        state_d = pop ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      timer_q <= '0;
      shift_q <= '0;
      idx_q <= '0;
      ser_q <= 1'b1;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      timer_q <= timer_d;
      shift_q <= shift_d;
      idx_q <= idx_d;
      ser_q <= ser_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) if (wr) mem[wptr_q] <= par_in_data;
  assign ser_out = ser_q;
  assign fifo_full = count_q == FULL;
  assign fifo_level = count_q;
  assign busy = state_q != IDLE || count_q != '0;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_console_uart_tx.sv
// tb_console_uart_tx: randomized-data checks of console_uart_tx against a frame-level line model.
module tb_console_uart_tx;
  localparam int TPB = 10;
  localparam int FRAME = 10 * TPB;
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic strobe = 1'b0;
  logic [7:0] data = 8'h00;
  logic ser_out, fifo_full, busy, overflow;
  logic [4:0] fifo_level;
  int errors = 0;
  int checks = 0;
  logic [7:0] line_q[$];
  logic [7:0] stream[17];
  console_uart_tx #(.CLKFREQ(1), .BAUD(100000), .DEPTH(16)) dut (
    .clk(clk), .n_reset(n_reset), .par_in_data(data), .par_in_strobe(strobe),
    .ser_out(ser_out), .fifo_full(fifo_full), .fifo_level(fifo_level),
    .busy(busy), .overflow(overflow)
  );
  always #5 clk = ~clk;
  // expected line level t cycles after the first start bit, frames of line_q back to back
  function automatic logic line_bit(input int t);
    int f, k;
    if (t < 0) return 1'b1;
    f = t / FRAME;
    k = (t % FRAME) / TPB;
    if (f >= line_q.size()) return 1'b1;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return line_q[f][k-1];
  endfunction
  task automatic test_reset();
    n_reset = 1'b0;
    strobe = 1'b0;
    repeat (3) @(negedge clk);
    checks += 5;
    if (ser_out !== 1'b1) begin errors++; $display("FAIL reset ser_out got %b exp 1", ser_out); end
    if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset fifo_full got %b exp 0", fifo_full); end
    if (fifo_level !== 5'd0) begin errors++; $display("FAIL reset fifo_level got %0d exp 0", fifo_level); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow got %b exp 0", overflow); end
    n_reset = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_single(input logic [7:0] b);
    line_q = {b};
    strobe = 1'b1;
    data = b;
    for (int t = -1; t <= FRAME; t++) begin
      @(negedge clk);
      strobe = 1'b0;
      checks += 2;
      if (ser_out !== line_bit(t)) begin errors++; $display("FAIL single %h ser_out t=%0d got %b exp %b", b, t, ser_out, line_bit(t)); end
      if (busy !== (t < FRAME)) begin errors++; $display("FAIL single %h busy t=%0d got %b exp %b", b, t, busy, t < FRAME); end
      if (t == -1 || t == 0) begin
        checks++;
        if (fifo_level !== 5'(t == -1)) begin errors++; $display("FAIL single level t=%0d got %0d exp %0d", t, fifo_level, t == -1); end
      end
    end
  endtask
  task automatic test_back_to_back();
    line_q = {8'h00, 8'hFF, 8'h55};
    strobe = 1'b1;
    data = 8'h00;
    for (int t = -1; t <= 3 * FRAME; t++) begin
      @(negedge clk);
      strobe = t < 1;
      data = t == -1 ? 8'hFF : 8'h55;
      checks += 2;
      if (ser_out !== line_bit(t)) begin errors++; $display("FAIL b2b ser_out t=%0d got %b exp %b", t, ser_out, line_bit(t)); end
      if (busy !== (t < 3 * FRAME)) begin errors++; $display("FAIL b2b busy t=%0d got %b exp %b", t, busy, t < 3 * FRAME); end
      if (t == 1 || t == 99 || t == 100 || t == 200) begin
        checks++;
        if (fifo_level !== (t < 100 ? 5'd2 : t < 200 ? 5'd1 : 5'd0)) begin
          errors++; $display("FAIL b2b level t=%0d got %0d", t, fifo_level);
        end
      end
    end
  endtask
  task automatic test_write_on_pop();
    logic [7:0] a, b, c;
    a = 8'($urandom);
    b = 8'($urandom);
    c = 8'($urandom);
    line_q = {a, b, c};
    strobe = 1'b1;
    data = a;
    for (int t = -1; t <= 3 * FRAME; t++) begin
      @(negedge clk);
      strobe = t == 0 || t == 99;
      data = t == 0 ? b : c;
      checks++;
      if (ser_out !== line_bit(t)) begin errors++; $display("FAIL wpop ser_out t=%0d got %b exp %b", t, ser_out, line_bit(t)); end
      if (t == 99 || t == 100 || t == 200 || t == 300) begin
        checks++;
        if (fifo_level !== 5'(t < 200)) begin errors++; $display("FAIL wpop level t=%0d got %0d exp %0d", t, fifo_level, t < 200); end
      end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wpop busy got %b exp 0", busy); end
  endtask
  task automatic test_overflow();
    line_q = {8'($urandom)};
    for (int i = 0; i < 17; i++) stream[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) line_q.push_back(stream[i]);
    strobe = 1'b1;
    data = line_q[0];
    for (int t = -1; t <= 17 * FRAME; t++) begin
      @(negedge clk);
      checks += 2;
      if (ser_out !== line_bit(t)) begin errors++; $display("FAIL ovf ser_out t=%0d got %b exp %b", t, ser_out, line_bit(t)); end
      if (overflow !== (t == 17)) begin errors++; $display("FAIL ovf overflow t=%0d got %b exp %b", t, overflow, t == 17); end
      if (t == 15 || t == 16 || t == 17 || t == 100) begin
        checks += 2;
        if (fifo_level !== (t == 15 || t == 100 ? 5'd15 : 5'd16)) begin errors++; $display("FAIL ovf level t=%0d got %0d", t, fifo_level); end
        if (fifo_full !== (t == 16 || t == 17)) begin errors++; $display("FAIL ovf full t=%0d got %b", t, fifo_full); end
      end
      strobe = t >= 0 && t < 17;
      data = t >= 0 && t < 17 ? stream[t] : 8'h00;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ovf busy got %b exp 0", busy); end
  endtask
  task automatic test_reset_mid();
    line_q = {8'($urandom)};
    for (int i = 0; i < 5; i++) stream[i] = 8'($urandom);
    strobe = 1'b1;
    data = line_q[0];
    for (int t = -1; t <= 400; t++) begin
      @(negedge clk);
      checks++;
      if (t < 55) begin
        if (ser_out !== line_bit(t)) begin errors++; $display("FAIL rmid ser_out t=%0d got %b exp %b", t, ser_out, line_bit(t)); end
      end else begin
        if (ser_out !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rmid idle t=%0d ser_out %b busy %b exp 1 0", t, ser_out, busy); end
      end
      if (t == 54 || t == 55) begin
        checks++;
        if (fifo_level !== (t == 54 ? 5'd5 : 5'd0)) begin errors++; $display("FAIL rmid level t=%0d got %0d", t, fifo_level); end
      end
      strobe = t >= 0 && t < 5;
      data = t >= 0 && t < 5 ? stream[t] : 8'h00;
      n_reset = t != 54;
    end
  endtask
  initial begin
    test_reset();
    test_single(8'hA5);
    test_single(8'($urandom));
    test_single(8'($urandom));
    test_back_to_back();
    test_write_on_pop();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
